// File: rtl/dec_strobe_pkg.sv
// Shared types and helpers for the timed one-hot write-strobe sequencer.
package dec_strobe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_t;

    localparam int SEL_W_MIN = 1;
    localparam int SEL_W_MAX = 8;
    localparam int PULSE_MIN = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable.
module dec_onehot
    import dec_strobe_pkg::*;
#(
    parameter int SEL_W = 5
) (
    input  logic                    en,
    input  logic [SEL_W-1:0]        sel,
    output logic [(1<<SEL_W)-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/dec_strobe.sv
// One-hot decoder feeding a registered write strobe with
// programmable setup, pulse width and hold.
module dec_strobe
    import dec_strobe_pkg::*;
#(
    parameter int SEL_W     = 5,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter bit MASK_ZERO = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SEL_W-1:0]        req_sel,
    output logic [SEL_W-1:0]        sel_q,
    output logic [(1<<SEL_W)-1:0]   strobe,
    output logic                    busy,
    output logic                    done
);

    localparam int OUT_W   = 1 << SEL_W;
    localparam int CNT_MAX = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int CNT_LOG = clog2(CNT_MAX + 1);
    localparam int CNT_W   = (CNT_LOG < 1) ? 1 : CNT_LOG;

    localparam logic [CNT_W-1:0] SETUP_LD =
        CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] PULSE_LD =
        CNT_W'((PULSE_CYC > 0) ? PULSE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD =
        CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX) begin : g_bad_sel
        $fatal(1, "dec_strobe: SEL_W out of range");
    end
    if (PULSE_CYC < PULSE_MIN) begin : g_bad_pulse
        $fatal(1, "dec_strobe: PULSE_CYC must be >= 1");
    end
    if (SETUP_CYC < 0 || HOLD_CYC < 0) begin : g_bad_time
        $fatal(1, "dec_strobe: negative SETUP_CYC/HOLD_CYC");
    end

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [SEL_W-1:0]   sel_d;
    logic               accept;
    logic               strobe_en;
    logic [OUT_W-1:0]   strobe_d;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign sel_d     = accept ? req_sel : sel_q;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (SETUP_CYC > 0) begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = PULSE;
                        cnt_d   = PULSE_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    if (HOLD_CYC > 0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode from next-state so the registered strobe lines up with PULSE
    assign strobe_en = (state_d == PULSE) && !(MASK_ZERO && (sel_d == '0));

    dec_onehot #(
        .SEL_W  (SEL_W)
    ) u_dec (
        .en     (strobe_en),
        .sel    (sel_d),
        .onehot (strobe_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sel_q  <= '0;
            strobe <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            sel_q  <= sel_d;
            strobe <= strobe_d;
            done   <= (state != IDLE) && (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_dec_strobe.sv
// Scoreboard bench for dec_strobe: default timing instance plus a
// minimal-timing SEL_W=3 instance.
module tb_dec_strobe;

    typedef struct {
        int          cy;
        logic [31:0] val;
    } ev_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;

    logic        rst_a = 1'b1;
    logic        vld_a = 1'b0;
    logic        rdy_a;
    logic [4:0]  sel_a = '0;
    logic [4:0]  selq_a;
    logic [31:0] strb_a;
    logic        busy_a;
    logic        done_a;

    logic        rst_b = 1'b1;
    logic        vld_b = 1'b0;
    logic        rdy_b;
    logic [2:0]  sel_b = '0;
    logic [2:0]  selq_b;
    logic [7:0]  strb_b;
    logic        busy_b;
    logic        done_b;

    ev_t qsa[$];
    ev_t qda[$];
    ev_t qsb[$];
    ev_t qdb[$];
    ev_t ea;
    ev_t eb;

    dec_strobe u_a (
        .clk       (clk),
        .rst       (rst_a),
        .req_valid (vld_a),
        .req_ready (rdy_a),
        .req_sel   (sel_a),
        .sel_q     (selq_a),
        .strobe    (strb_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    dec_strobe #(
        .SEL_W     (3),
        .SETUP_CYC (0),
        .PULSE_CYC (1),
        .HOLD_CYC  (0),
        .MASK_ZERO (1'b1)
    ) u_b (
        .clk       (clk),
        .rst       (rst_b),
        .req_valid (vld_b),
        .req_ready (rdy_b),
        .req_sel   (sel_b),
        .sel_q     (selq_b),
        .strobe    (strb_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok,
                       input longint act, input longint exp);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(ref ev_t q[$], input int cy, input logic [31:0] v);
        ev_t e;
        e.cy  = cy;
        e.val = v;
        q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic accept_a(input logic [4:0] s, output int c);
        int n;
        vld_a = 1'b1;
        sel_a = s;
        n = 0;
        while (!rdy_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_accept", rdy_a, longint'(rdy_a), 1);
        c = cyc;
        @(negedge clk);
    endtask

    task automatic accept_b(input logic [2:0] s, output int c);
        int n;
        vld_b = 1'b1;
        sel_b = s;
        n = 0;
        while (!rdy_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b_accept", rdy_b, longint'(rdy_b), 1);
        c = cyc;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        chk("a_onehot", $countones(strb_a) <= 1, longint'(strb_a), 0);
        if (strb_a != '0) begin
            chk("a_strobe_unexp", qsa.size() != 0, longint'(strb_a), 0);
            if (qsa.size() != 0) begin
                ea = qsa.pop_front();
                chk("a_strobe_val", strb_a == ea.val,
                    longint'(strb_a), longint'(ea.val));
                chk("a_strobe_cyc", cyc == ea.cy, cyc, ea.cy);
            end
        end
        if (done_a) begin
            chk("a_done_unexp", qda.size() != 0, cyc, 0);
            if (qda.size() != 0) begin
                ea = qda.pop_front();
                chk("a_done_cyc", cyc == ea.cy, cyc, ea.cy);
            end
        end
        if (strb_b != '0) begin
            chk("b_strobe_unexp", qsb.size() != 0, longint'(strb_b), 0);
            if (qsb.size() != 0) begin
                eb = qsb.pop_front();
                chk("b_strobe_val", {24'h0, strb_b} == eb.val,
                    longint'(strb_b), longint'(eb.val));
                chk("b_strobe_cyc", cyc == eb.cy, cyc, eb.cy);
            end
        end
        if (done_b) begin
            chk("b_done_unexp", qdb.size() != 0, cyc, 0);
            if (qdb.size() != 0) begin
                eb = qdb.pop_front();
                chk("b_done_cyc", cyc == eb.cy, cyc, eb.cy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int c2;

        repeat (3) @(negedge clk);
        chk("a_rst_strobe", strb_a == '0, longint'(strb_a), 0);
        chk("a_rst_selq", selq_a == '0, longint'(selq_a), 0);
        chk("a_rst_busy", busy_a == 1'b0, longint'(busy_a), 0);
        chk("a_rst_done", done_a == 1'b0, longint'(done_a), 0);
        chk("a_rst_ready", rdy_a == 1'b1, longint'(rdy_a), 1);
        chk("b_rst_strobe", strb_b == '0, longint'(strb_b), 0);
        chk("b_rst_ready", rdy_b == 1'b1, longint'(rdy_b), 1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // single request, sel 7
        accept_a(5'd7, c);
        vld_a = 1'b0;
        push(qsa, c + 2, 32'h0000_0080);
        push(qsa, c + 3, 32'h0000_0080);
        push(qda, c + 5, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            chk("a7_busy", busy_a == 1'b1, longint'(busy_a), 1);
            chk("a7_selq", selq_a == 5'd7, longint'(selq_a), 7);
            chk("a7_ready", rdy_a == 1'b0, longint'(rdy_a), 0);
            @(negedge clk);
        end
        chk("a7_idle_busy", busy_a == 1'b0, longint'(busy_a), 0);
        chk("a7_idle_ready", rdy_a == 1'b1, longint'(rdy_a), 1);
        chk("a7_idle_done", done_a == 1'b1, longint'(done_a), 1);
        repeat (2) @(negedge clk);

        // back-to-back 3 then 31; sel changes while busy
        accept_a(5'd3, c);
        sel_a = 5'd31;
        push(qsa, c + 2, 32'h0000_0008);
        push(qsa, c + 3, 32'h0000_0008);
        push(qda, c + 5, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            chk("b2b_selq3", selq_a == 5'd3, longint'(selq_a), 3);
            @(negedge clk);
            if (k == 2) sel_a = 5'd31;
        end
        accept_a(5'd31, c2);
        vld_a = 1'b0;
        chk("b2b_period", (c2 - c) == 5, c2 - c, 5);
        push(qsa, c2 + 2, 32'h8000_0000);
        push(qsa, c2 + 3, 32'h8000_0000);
        push(qda, c2 + 5, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            chk("b2b_selq31", selq_a == 5'd31, longint'(selq_a), 31);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // masked index 0
        accept_a(5'd0, c);
        vld_a = 1'b0;
        push(qda, c + 5, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            chk("m0_busy", busy_a == 1'b1, longint'(busy_a), 1);
            chk("m0_strobe", strb_a == '0, longint'(strb_a), 0);
            @(negedge clk);
        end
        chk("m0_idle_busy", busy_a == 1'b0, longint'(busy_a), 0);
        repeat (2) @(negedge clk);

        // reset in the first PULSE cycle
        accept_a(5'd9, c);
        vld_a = 1'b0;
        push(qsa, c + 2, 32'h0000_0200);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("rst_strobe", strb_a == '0, longint'(strb_a), 0);
        chk("rst_busy", busy_a == 1'b0, longint'(busy_a), 0);
        chk("rst_ready", rdy_a == 1'b1, longint'(rdy_a), 1);
        chk("rst_done", done_a == 1'b0, longint'(done_a), 0);
        chk("rst_selq", selq_a == '0, longint'(selq_a), 0);
        rst_a = 1'b0;
        repeat (4) @(negedge clk);
        accept_a(5'd20, c);
        vld_a = 1'b0;
        push(qsa, c + 2, 32'h0010_0000);
        push(qsa, c + 3, 32'h0010_0000);
        push(qda, c + 5, 32'h0);
        repeat (6) @(negedge clk);

        // minimal timing instance, back-to-back 5 then 2
        accept_b(3'd5, c);
        sel_b = 3'd2;
        push(qsb, c + 1, 32'h0000_0020);
        push(qdb, c + 2, 32'h0);
        chk("bq_busy", busy_b == 1'b1, longint'(busy_b), 1);
        chk("bq_selq", selq_b == 3'd5, longint'(selq_b), 5);
        accept_b(3'd2, c2);
        vld_b = 1'b0;
        chk("bq_period", (c2 - c) == 2, c2 - c, 2);
        push(qsb, c2 + 1, 32'h0000_0004);
        push(qdb, c2 + 2, 32'h0);
        repeat (4) @(negedge clk);

        chk("a_strobe_left", qsa.size() == 0, qsa.size(), 0);
        chk("a_done_left", qda.size() == 0, qda.size(), 0);
        chk("b_strobe_left", qsb.size() == 0, qsb.size(), 0);
        chk("b_done_left", qdb.size() == 0, qdb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/dec_strobe.md
Name: dec_strobe

Overview:
Parametrised SEL_W-to-2^SEL_W one-hot decoder with a timed, registered write-strobe sequencer. It generalises the fixed 5-to-32 select decoders used for register-file and memory write enables. It adds programmable address setup, strobe width and hold/recovery cycles, an optional zero-index mask for x0, and a valid/ready request handshake. It sits between the writeback stage and register-file/SRAM banks that need a clean, glitch-free, multi-cycle write pulse.

Parameters:
SEL_W, 5, select width; output width is 2^SEL_W; legal 1..8
SETUP_CYC, 1, cycles the latched select is held before the strobe asserts; legal >=0
PULSE_CYC, 2, cycles the strobe stays asserted; legal >=1
HOLD_CYC, 1, cycles the select is held after the strobe deasserts; legal >=0
MASK_ZERO, 1, 1 = index 0 never produces a strobe bit (timing still runs)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_sel  in  SEL_W  target index, sampled on accept
sel_q  out  SEL_W  latched index, stable from accept+1 until return to IDLE
strobe  out  2^SEL_W  registered one-hot write strobe
busy  out  1  high in SETUP, PULSE and HOLD
done  out  1  single-cycle pulse in the first IDLE cycle after a sequence

Behaviour:
- Reset (rst sampled high): state=IDLE, strobe=0, sel_q=0, busy=0, done=0, counter=0. Reset has priority over every other event.
- Reset mid-sequence: all outputs are 0 (req_ready=1) in the cycle after the edge. No done pulse is produced and the aborted request is lost.
- FSM states are IDLE, SETUP, PULSE and HOLD. A down-counter is sized to clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1).
- req_ready = (state==IDLE), combinational from state. Accept occurs when req_valid && req_ready. req_valid while not ready is ignored; the requester holds the request.
- On accept at edge t, sel_q<=req_sel. The next state is SETUP (counter=SETUP_CYC-1) if SETUP_CYC>0, else PULSE.
- SETUP lasts SETUP_CYC cycles, then PULSE. PULSE lasts PULSE_CYC cycles.
- After PULSE, go to HOLD for HOLD_CYC cycles if HOLD_CYC>0, else go to IDLE.
- strobe is a register: strobe = onehot(sel_q) exactly in cycles where state==PULSE, else 0. It never glitches or has more than one bit set.
- MASK_ZERO=1 and sel_q==0: strobe stays all-zero, while busy, sel_q, timing and done behave identically.
- done is registered and is 1 only in the first IDLE cycle after completion. In that same cycle req_ready=1, so a new accept there is legal (back-to-back).
- Minimum request period = 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles. With defaults, accept at cycle 0 gives:
  - SETUP at cycle 1
  - strobe at cycles 2–3
  - HOLD at cycle 4
  - IDLE with done=1 at cycle 5
- Elaboration checks: an illegal SEL_W or PULSE_CYC==0 is a fatal elaboration error.

Decomposition:
- Shared package: state enum (IDLE, SETUP, PULSE, HOLD), a clog2 helper, and the legal parameter limits.
- One natural sub-module: dec_onehot, a purely combinational, parametrised SEL_W-to-2^SEL_W decoder with an enable input. dec_strobe instantiates it and registers its output.

Test Plan:
- Defaults, accept req_sel=7 at cycle 0 -> strobe=0x00000080 in cycles 2–3 only; busy in cycles 1–4; done=1 in cycle 5; sel_q=7 in cycles 1–4.
- Back-to-back: req_valid held high with sel 3 then 31 -> second accept in cycle 5; strobe=0x80000000 in cycles 7–8; periods exactly 5 cycles apart; no overlap.
- MASK_ZERO=1, req_sel=0 -> strobe stays 0 for the whole sequence; busy cycles 1–4; done in cycle 5.
- Reset asserted in cycle 2 (mid-PULSE) -> cycle 3: strobe=0, busy=0, req_ready=1, no done pulse; a new request accepted afterwards completes normally.
- SEL_W=3, SETUP_CYC=0, PULSE_CYC=1, HOLD_CYC=0, req_sel=5 -> strobe=0x20 in cycle 1; done in cycle 2; period 2 cycles.
- req_valid high while busy with changing req_sel -> ignored; sel_q and strobe unaffected until the next IDLE accept.
